// File: rtl/leaf_feeder.sv
// Multi-channel input buffer feeding the leaf sorter stage: preloads every channel,
// then serves queued per-channel requests in order, with an all-ones sentinel for drained streams.
module leaf_feeder #(
    parameter int W_LOG     = 2,
    parameter int FIFO_SIZE = 3,
    parameter int PRELOAD   = 2,
    parameter int DATW      = 64,
    parameter int KEYW      = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_ENQ,
    input  logic [W_LOG-1:0]        IN_IDX,
    input  logic [DATW-1:0]         IN_DATA,
    input  logic                    IN_LAST,
    output logic [(1<<W_LOG)-1:0]   IN_FULL,
    input  logic [W_LOG-1:0]        REQ,
    input  logic                    REQ_VALID,
    output logic [DATW-1:0]         DOT,
    output logic                    DOTEN,
    output logic [W_LOG-1:0]        DOT_IDX,
    output logic                    INIT_DONE,
    output logic                    ERR
);

    localparam int NCH = 1 << W_LOG;
    localparam int MAW = W_LOG + FIFO_SIZE;
    localparam int QAW = W_LOG + FIFO_SIZE;
    localparam logic [FIFO_SIZE:0] PL_LAST = (FIFO_SIZE+1)'(PRELOAD - 1);

    if (KEYW > DATW) begin : g_keyw_chk
        $error("KEYW must not exceed DATW");
    end

    typedef enum logic {S_INIT, S_RUN} state_t;

    logic [FIFO_SIZE:0] r_head [NCH];
    logic [FIFO_SIZE:0] r_tail [NCH];
    logic [NCH-1:0]     r_done;
    logic [DATW-1:0]    r_mem  [1<<MAW];
    logic [W_LOG-1:0]   r_q    [1<<QAW];
    logic [QAW:0]       r_qwr;
    logic [QAW:0]       r_qrd;
    state_t             r_state;
    logic [W_LOG-1:0]   r_ch;
    logic [FIFO_SIZE:0] r_pcnt;
    logic [DATW-1:0]    r_dot_p1;
    logic               r_vld_p1;
    logic [W_LOG-1:0]   r_idx_p1;
    logic               r_init_done;
    logic               r_err;

    logic [NCH-1:0]     w_empty;
    logic [NCH-1:0]     w_full;
    logic [NCH-1:0]     w_avail;
    logic               w_qempty;
    logic               w_qfull;
    logic [W_LOG-1:0]   w_qhead;
    logic [W_LOG-1:0]   w_ich;
    logic               w_iss;
    logic               w_rd;
    logic               w_wr;
    logic               w_push;
    logic               w_pop;
    logic [MAW-1:0]     w_raddr;
    logic [MAW-1:0]     w_waddr;

    always_comb begin
        w_empty = '0;
        w_full  = '0;
        for (int c = 0; c < NCH; c++) begin
            w_empty[c] = (r_head[c] == r_tail[c]);
            w_full[c]  = (r_head[c][FIFO_SIZE] != r_tail[c][FIFO_SIZE]) &&
                         (r_head[c][FIFO_SIZE-1:0] == r_tail[c][FIFO_SIZE-1:0]);
        end
    end

    // A done channel stays servable after draining: it then yields the sentinel.
    assign w_avail  = ~w_empty | r_done;
    assign w_qempty = (r_qwr == r_qrd);
    assign w_qfull  = (r_qwr[QAW] != r_qrd[QAW]) && (r_qwr[QAW-1:0] == r_qrd[QAW-1:0]);
    assign w_qhead  = r_q[r_qrd[QAW-1:0]];

    always_comb begin
        w_ich = r_ch;
        w_iss = 1'b0;
        if (r_state == S_INIT) begin
            w_ich = r_ch;
            w_iss = w_avail[r_ch];
        end else begin
            w_ich = w_qhead;
            w_iss = !w_qempty && w_avail[w_qhead];
        end
    end

    assign w_rd    = w_iss && !w_empty[w_ich];
    assign w_wr    = IN_ENQ && !w_full[IN_IDX];
    assign w_push  = REQ_VALID && !w_qfull;
    assign w_pop   = w_iss && (r_state == S_RUN);
    assign w_raddr = {w_ich, r_head[w_ich][FIFO_SIZE-1:0]};
    assign w_waddr = {IN_IDX, r_tail[IN_IDX][FIFO_SIZE-1:0]};

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[w_waddr] <= IN_DATA;
        end
        if (w_push) begin
            r_q[r_qwr[QAW-1:0]] <= REQ;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < NCH; c++) begin
                r_head[c] <= '0;
                r_tail[c] <= '0;
            end
            r_done      <= '0;
            r_qwr       <= '0;
            r_qrd       <= '0;
            r_state     <= S_INIT;
            r_ch        <= '0;
            r_pcnt      <= '0;
            r_dot_p1    <= '0;
            r_vld_p1    <= 1'b0;
            r_idx_p1    <= '0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_rd && (w_ich == W_LOG'(c))) begin
                    r_head[c] <= r_head[c] + 1'b1;
                end
                if (w_wr && (IN_IDX == W_LOG'(c))) begin
                    r_tail[c] <= r_tail[c] + 1'b1;
                end
                if (IN_ENQ && IN_LAST && (IN_IDX == W_LOG'(c))) begin
                    r_done[c] <= 1'b1;
                end
            end

            // Output stage: registered memory read or sentinel
            r_vld_p1 <= w_iss;
            if (w_iss) begin
                r_idx_p1 <= w_ich;
                r_dot_p1 <= w_rd ? r_mem[w_raddr] : {DATW{1'b1}};
            end

            if (w_push) begin
                r_qwr <= r_qwr + 1'b1;
            end
            if (w_pop) begin
                r_qrd <= r_qrd + 1'b1;
            end

            if ((IN_ENQ && w_full[IN_IDX]) || (REQ_VALID && w_qfull)) begin
                r_err <= 1'b1;
            end

            if ((r_state == S_INIT) && w_iss) begin
                if (r_pcnt == PL_LAST) begin
                    r_pcnt <= '0;
                    if (r_ch == W_LOG'(NCH - 1)) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end
        end
    end

    assign IN_FULL   = w_full;
    assign DOT       = r_dot_p1;
    assign DOTEN     = r_vld_p1;
    assign DOT_IDX   = r_idx_p1;
    assign INIT_DONE = r_init_done;
    assign ERR       = r_err;

endmodule

// File: tb/tb_leaf_feeder.sv
// Directed bench for leaf_feeder: preload order, request latency, blocking order,
// sentinel on drained streams, overflow flag and mid-stream reset.
module tb_leaf_feeder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_ENQ = 1'b0;
    logic [1:0]  IN_IDX = '0;
    logic [63:0] IN_DATA = '0;
    logic        IN_LAST = 1'b0;
    logic [3:0]  IN_FULL;
    logic [1:0]  REQ = '0;
    logic        REQ_VALID = 1'b0;
    logic [63:0] DOT;
    logic        DOTEN;
    logic [1:0]  DOT_IDX;
    logic        INIT_DONE;
    logic        ERR;

    leaf_feeder dut (
        .CLK(CLK), .RST(RST),
        .IN_ENQ(IN_ENQ), .IN_IDX(IN_IDX), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
        .IN_FULL(IN_FULL),
        .REQ(REQ), .REQ_VALID(REQ_VALID),
        .DOT(DOT), .DOTEN(DOTEN), .DOT_IDX(DOT_IDX),
        .INIT_DONE(INIT_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] log_dat[$];
    logic [1:0]  log_idx[$];
    int          log_cyc[$];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (DOTEN === 1'b1) begin
            log_dat.push_back(DOT);
            log_idx.push_back(DOT_IDX);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] elem(input int c, input int k);
        return {32'hC0DE_0000 + 32'(c), 32'(c * 8 + k + 3)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic [1:0] ch, input logic [63:0] d, input logic last);
        IN_ENQ  = 1'b1;
        IN_IDX  = ch;
        IN_DATA = d;
        IN_LAST = last;
        step();
        IN_ENQ  = 1'b0;
        IN_LAST = 1'b0;
    endtask

    task automatic req(input logic [1:0] ch);
        REQ       = ch;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
    endtask

    task automatic clear_log();
        log_dat.delete();
        log_idx.delete();
        log_cyc.delete();
    endtask

    task automatic wait_log(input string tag, input int n);
        int b = 0;
        while (log_dat.size() < n && b < 100) begin
            step();
            b++;
        end
        check(tag, 64'(log_dat.size()), 64'(n));
    endtask

    task automatic check_pop(input string tag, input logic [1:0] idx, input logic [63:0] dat);
        logic [63:0] gd;
        logic [1:0]  gi;
        int          gc;
        gd = 'x;
        gi = 'x;
        if (log_dat.size() > 0) begin
            gd = log_dat.pop_front();
            gi = log_idx.pop_front();
            gc = log_cyc.pop_front();
        end
        check({tag, "_idx"}, 64'(gi), 64'(idx));
        check({tag, "_dat"}, gd, dat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        #2;
        check("rst_doten", 64'(DOTEN), 64'd0);
        check("rst_dot", DOT, 64'd0);
        check("rst_idx", 64'(DOT_IDX), 64'd0);
        check("rst_initdone", 64'(INIT_DONE), 64'd0);
        check("rst_err", 64'(ERR), 64'd0);
        check("rst_full", 64'(IN_FULL), 64'd0);
        step();
        step();
        RST = 1'b0;

        // preload: 3 elements per channel, 2 served each in channel order
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 3; k++)
                enq(2'(c), elem(c, k), 1'b0);
        wait_log("pre_cnt", 8);
        for (int i = 0; i < 8; i++)
            check_pop($sformatf("pre%0d", i), 2'(i / 2), elem(i / 2, i % 2));
        step();
        check("pre_initdone", 64'(INIT_DONE), 64'd1);
        check("pre_err", 64'(ERR), 64'd0);

        // single request latency: ch2 holds key 0x15
        clear_log();
        req(2'd2);
        check("lat_t1_doten", 64'(DOTEN), 64'd0);
        step();
        check("lat_t2_doten", 64'(DOTEN), 64'd1);
        check("lat_t2_key", 64'(DOT[31:0]), 64'h15);
        check("lat_t2_dat", DOT, elem(2, 2));
        check("lat_t2_idx", 64'(DOT_IDX), 64'd2);
        step();
        check("lat_t3_doten", 64'(DOTEN), 64'd0);
        clear_log();

        // head-of-line blocking on empty, not-done ch1
        req(2'd1);
        repeat (3) step();
        check_pop("blk_drain", 2'd1, elem(1, 2));
        req(2'd1);
        req(2'd3);
        repeat (5) step();
        check("blk_none", 64'(log_dat.size()), 64'd0);
        enq(2'd1, 64'h7, 1'b0);
        wait_log("blk_cnt", 2);
        check_pop("blk_first", 2'd1, 64'h7);
        check_pop("blk_second", 2'd3, elem(3, 2));

        // sentinel after last element, back-to-back without stall
        clear_log();
        req(2'd0);
        repeat (3) step();
        check_pop("snt_drain", 2'd0, elem(0, 2));
        enq(2'd0, 64'h1234_5678_0000_0042, 1'b1);
        req(2'd0);
        req(2'd0);
        req(2'd0);
        wait_log("snt_cnt", 3);
        if (log_cyc.size() >= 3)
            check("snt_nostall", 64'(log_cyc[2] - log_cyc[0]), 64'd2);
        check_pop("snt0", 2'd0, 64'h1234_5678_0000_0042);
        check_pop("snt1", 2'd0, {64{1'b1}});
        check_pop("snt2", 2'd0, {64{1'b1}});

        // overflow of ch3
        clear_log();
        for (int k = 0; k < 7; k++)
            enq(2'd3, 64'h3300 + 64'(k), 1'b0);
        check("ovf_full7", 64'(IN_FULL), 64'h0);
        enq(2'd3, 64'h3307, 1'b0);
        check("ovf_full8", 64'(IN_FULL), 64'h8);
        check("ovf_err_before", 64'(ERR), 64'd0);
        enq(2'd3, 64'hDEAD, 1'b0);
        check("ovf_err", 64'(ERR), 64'd1);
        check("ovf_full9", 64'(IN_FULL), 64'h8);
        for (int k = 0; k < 8; k++)
            req(2'd3);
        wait_log("ovf_cnt", 8);
        for (int k = 0; k < 8; k++)
            check_pop($sformatf("ovf%0d", k), 2'd3, 64'h3300 + 64'(k));
        check("ovf_err_sticky", 64'(ERR), 64'd1);

        // mid-stream reset with pending requests
        clear_log();
        for (int k = 0; k < 8; k++)
            enq(2'd2, 64'h5500 + 64'(k), 1'b0);
        check("mrst_full_pre", 64'(IN_FULL), 64'h4);
        for (int i = 0; i < 5; i++)
            req(2'd1);
        step();
        RST = 1'b1;
        #2;
        check("mrst_doten", 64'(DOTEN), 64'd0);
        check("mrst_dot", DOT, 64'd0);
        check("mrst_idx", 64'(DOT_IDX), 64'd0);
        check("mrst_initdone", 64'(INIT_DONE), 64'd0);
        check("mrst_err", 64'(ERR), 64'd0);
        check("mrst_full", 64'(IN_FULL), 64'd0);
        step();
        step();
        RST = 1'b0;
        clear_log();
        for (int k = 0; k < 3; k++)
            enq(2'd1, elem(1, k), 1'b0);
        enq(2'd0, elem(0, 0), 1'b0);
        enq(2'd0, elem(0, 1), 1'b0);
        for (int c = 2; c < 4; c++)
            for (int k = 0; k < 2; k++)
                enq(2'(c), elem(c, k), 1'b0);
        wait_log("mrst_pre_cnt", 8);
        for (int i = 0; i < 8; i++)
            check_pop($sformatf("mrst_pre%0d", i), 2'(i / 2), elem(i / 2, i % 2));
        repeat (10) step();
        check("mrst_qempty", 64'(log_dat.size()), 64'd0);
        check("mrst_initdone2", 64'(INIT_DONE), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
